// File: rtl/uart_pkg.sv
// Shared UART definitions: the receiver state encoding and the 12 MHz / 9600 baud link constants.
package uart_pkg;

  localparam int UART_CLK_HZ       = 12_000_000;
  localparam int UART_BAUD         = 9600;
  localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input pin; both flops reset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_r;

  // Two-stage capture of the asynchronous pin.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_r <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      meta_r <= i_d;
      o_q    <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at half a bit, mid-bit data sampling,
// one-cycle valid / frame-error pulses on completion of each frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  uart_rx_state_t state_r;
  logic [CW-1:0]  cnt_r;
  logic [2:0]     bit_idx_r;
  logic [7:0]     shift_r;
  logic           rx_s;

  // Idle level is 1, so a reset never fabricates a falling edge.
  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  // Receive FSM with bit-period counter, shift register and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            cnt_r   <= '0;
            o_busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == HALF_M1) begin
            cnt_r <= '0;
            if (!rx_s) begin
              state_r   <= DATA;
              bit_idx_r <= 3'd0;
            end else begin
              // Line came back high before mid start bit: treat as a glitch.
              state_r <= IDLE;
              o_busy  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == FULL_M1) begin
            cnt_r     <= '0;
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_r <= '0;
            if (rx_s) begin
              o_data  <= shift_r;
              o_valid <= 1'b1;
              state_r <= IDLE;
              o_busy  <= 1'b0;
            end else begin
              // Stay out of IDLE until the line recovers so a break reports once.
              o_frame_err <= 1'b1;
              state_r     <= WAIT_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_r <= IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (16 clk/bit) for the functional cases
// and a default-rate instance driven 3 % slow.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, ferr_a, busy_a;
  logic       valid_b, ferr_b, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_fall  = 0;

  int         va_cnt   = 0;
  int         fe_cnt   = 0;
  int         both_cnt = 0;
  logic [7:0] va_data [0:15];
  int         va_cyc  [0:15];
  int         vb_cnt   = 0;
  int         feb_cnt  = 0;
  logic [7:0] vb_data  = 8'h00;
  int         vb_cyc   = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(16)) u_dut_a (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx_a),
    .o_data      (data_a),
    .o_valid     (valid_a),
    .o_frame_err (ferr_a),
    .o_busy      (busy_a)
  );

  uart_rx u_dut_b (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx_b),
    .o_data      (data_b),
    .o_valid     (valid_b),
    .o_frame_err (ferr_b),
    .o_busy      (busy_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid_a) begin
      va_data[va_cnt[3:0]] <= data_a;
      va_cyc[va_cnt[3:0]]  <= cyc;
      va_cnt               <= va_cnt + 1;
    end
    if (ferr_a) fe_cnt <= fe_cnt + 1;
    if (valid_a && ferr_a) both_cnt <= both_cnt + 1;
    if (valid_b) begin
      vb_cnt  <= vb_cnt + 1;
      vb_data <= data_b;
      vb_cyc  <= cyc;
    end
    if (ferr_b) feb_cnt <= feb_cnt + 1;
    if (valid_b && ferr_b) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive frame cycles [i0, i1) of an 8N1 frame at cpb clocks per bit on line a or b.
  task automatic drive(input bit sel, input logic [7:0] b, input logic stop,
                       input int cpb, input int i0, input int i1);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = i0; i < i1; i++) begin
      @(negedge clk);
      if (i == 0) t_fall = cyc;
      if (sel) rx_b = frame[i / cpb];
      else     rx_a = frame[i / cpb];
    end
  endtask

  initial begin
    int base;
    int fbase;
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    idle(5);
    check_eq("rst_data",  {24'd0, data_a}, 32'h00);
    check_eq("rst_valid", {31'd0, valid_a}, 32'd0);
    check_eq("rst_ferr",  {31'd0, ferr_a}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    idle(10);

    // Normal byte: valid at t0 + 8 + 144 + 1, t0 = pin fall + 2.
    drive(1'b0, 8'hA5, 1'b1, 16, 0, 40);
    check_eq("busy_mid", {31'd0, busy_a}, 32'd1);
    drive(1'b0, 8'hA5, 1'b1, 16, 40, 160);
    idle(20);
    check_eq("a5_count", va_cnt, 32'd1);
    check_eq("a5_data",  {24'd0, va_data[0]}, 32'hA5);
    check_eq("a5_time",  va_cyc[0] - t_fall, 32'd155);
    check_eq("a5_ferr",  fe_cnt, 32'd0);
    check_eq("a5_busy",  {31'd0, busy_a}, 32'd0);

    // Back-to-back, zero idle gap.
    base = va_cnt;
    drive(1'b0, 8'h00, 1'b1, 16, 0, 160);
    drive(1'b0, 8'hFF, 1'b1, 16, 0, 160);
    idle(20);
    check_eq("b2b_count", va_cnt - base, 32'd2);
    check_eq("b2b_d0",    {24'd0, va_data[1]}, 32'h00);
    check_eq("b2b_d1",    {24'd0, va_data[2]}, 32'hFF);
    check_eq("b2b_gap",   va_cyc[2] - va_cyc[1], 32'd160);

    // Start glitch of 3 cycles.
    base  = va_cnt;
    fbase = fe_cnt;
    repeat (3) begin
      @(negedge clk);
      rx_a = 1'b0;
    end
    @(negedge clk);
    rx_a = 1'b1;
    idle(12);
    check_eq("glitch_busy",  {31'd0, busy_a}, 32'd0);
    check_eq("glitch_valid", va_cnt - base, 32'd0);
    check_eq("glitch_ferr",  fe_cnt - fbase, 32'd0);
    idle(10);
    drive(1'b0, 8'h3C, 1'b1, 16, 0, 160);
    idle(20);
    check_eq("3c_count", va_cnt - base, 32'd1);
    check_eq("3c_data",  {24'd0, va_data[3]}, 32'h3C);

    // Framing error followed by a 500-cycle break.
    base  = va_cnt;
    fbase = fe_cnt;
    drive(1'b0, 8'h81, 1'b0, 16, 0, 160);
    idle(500);
    @(negedge clk);
    rx_a = 1'b1;
    idle(20);
    check_eq("fe_count",  fe_cnt - fbase, 32'd1);
    check_eq("fe_valid",  va_cnt - base, 32'd0);
    check_eq("fe_hold",   {24'd0, data_a}, 32'h3C);
    check_eq("fe_busy",   {31'd0, busy_a}, 32'd0);
    drive(1'b0, 8'h42, 1'b1, 16, 0, 160);
    idle(20);
    check_eq("42_data", {24'd0, va_data[4]}, 32'h42);

    // Reset in the middle of data bit 4.
    base  = va_cnt;
    fbase = fe_cnt;
    drive(1'b0, 8'h5A, 1'b1, 16, 0, 16 * 5 + 8);
    @(negedge clk);
    rst  = 1'b1;
    rx_a = 1'b1;
    #1;
    check_eq("mrst_data",  {24'd0, data_a}, 32'h00);
    check_eq("mrst_busy",  {31'd0, busy_a}, 32'd0);
    check_eq("mrst_valid", {31'd0, valid_a}, 32'd0);
    idle(4);
    rst = 1'b0;
    idle(200);
    check_eq("mrst_nopulse", (va_cnt - base) + (fe_cnt - fbase), 32'd0);
    drive(1'b0, 8'h5A, 1'b1, 16, 0, 160);
    idle(20);
    check_eq("5a_data", {24'd0, va_data[5]}, 32'h5A);

    // Default rate, transmitter 3 % slow (1288 clocks per bit).
    drive(1'b1, 8'h55, 1'b1, 1288, 0, 12880);
    idle(30);
    check_eq("dflt_count", vb_cnt, 32'd1);
    check_eq("dflt_data",  {24'd0, vb_data}, 32'h55);
    check_eq("dflt_time",  vb_cyc - t_fall, 32'd11878);
    check_eq("dflt_ferr",  feb_cnt, 32'd0);

    check_eq("pulse_excl", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
